// File: rtl/ccd_line_avg_if.sv
// AXI4-Stream video link: tuser marks start of frame, tlast marks end of line.
interface ccd_line_avg_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (
      output tdata, tvalid, tlast, tuser,
      input  tready
   );

   modport slave (
      input  tdata, tvalid, tlast, tuser,
      output tready
   );
endinterface

// File: rtl/ccd_line_avg.sv
// Column-wise average of 2^AVG_SHIFT consecutive CCD lines.
// Two-stage pipeline: S0 handshake + RAM read, S1 accumulate or emit.
module ccd_line_avg #(
   parameter int DATA_WIDTH = 8,
   parameter int COLS       = 2048,
   parameter int AVG_SHIFT  = 2,
   parameter int ADDR_W     = 11
) (
   input  logic           pixel_clk,
   input  logic           rst_n,
   ccd_line_avg_if.slave  s_axis,
   ccd_line_avg_if.master m_axis,
   output logic           line_err
);
   localparam int SW = DATA_WIDTH + AVG_SHIFT;
   localparam int LW = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
   localparam logic [LW-1:0]     LAST_LINE = LW'((1 << AVG_SHIFT) - 1);
   localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pix;
      logic                  last;
      logic [ADDR_W-1:0]     col;
      logic [LW-1:0]         lidx;
   } s1_t;

   logic [SW-1:0]     mem [COLS];
   logic [SW-1:0]     rd_data;
   logic [SW-1:0]     sum;
   s1_t               s1;
   logic              s1_valid;
   logic              s1_final;
   logic              stall;
   logic              accept;
   logic              s1_adv;
   logic              load;
   logic              sof_pend;
   logic [ADDR_W-1:0] col_ptr;
   logic [ADDR_W-1:0] cur_col;
   logic [LW-1:0]     line_idx;
   logic [LW-1:0]     cur_lidx;

   assign s1_final      = s1.lidx == LAST_LINE;
   assign stall         = s1_valid && s1_final && m_axis.tvalid && !m_axis.tready;
   assign s_axis.tready = !stall;
   assign accept        = s_axis.tvalid && s_axis.tready;
   assign s1_adv        = s1_valid && !stall;
   assign load          = s1_adv && s1_final;

   // A frame start restarts the group at column 0 of line 0.
   assign cur_col  = s_axis.tuser ? '0 : col_ptr;
   assign cur_lidx = s_axis.tuser ? '0 : line_idx;

   assign sum = ((s1.lidx == '0) ? '0 : rd_data) + SW'(s1.pix);

   always_ff @(posedge pixel_clk) begin
      if (s1_adv && !s1_final) mem[s1.col] <= sum;
      if (accept) rd_data <= mem[cur_col];
   end

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= '0;
         s1_valid <= 1'b0;
         col_ptr  <= '0;
         line_idx <= '0;
         sof_pend <= 1'b0;
         line_err <= 1'b0;
      end else begin
         line_err <= 1'b0;
         if (accept) begin
            s1_valid <= 1'b1;
            s1.pix   <= s_axis.tdata;
            s1.last  <= s_axis.tlast;
            s1.col   <= cur_col;
            s1.lidx  <= cur_lidx;
            if (s_axis.tlast) begin
               col_ptr  <= '0;
               line_idx <= (cur_lidx + LW'(1)) & LAST_LINE;
               line_err <= cur_col != LAST_COL;
            end else if (cur_col == LAST_COL) begin
               col_ptr  <= '0;
               line_idx <= cur_lidx;
               line_err <= 1'b1;
            end else begin
               col_ptr  <= cur_col + ADDR_W'(1);
               line_idx <= cur_lidx;
            end
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
         // A new frame start wins over clearing by an older group's beat.
         if (accept && s_axis.tuser) sof_pend <= 1'b1;
         else if (load)              sof_pend <= 1'b0;
      end
   end

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis.tvalid <= 1'b0;
         m_axis.tdata  <= '0;
         m_axis.tlast  <= 1'b0;
         m_axis.tuser  <= 1'b0;
      end else if (load) begin
         m_axis.tvalid <= 1'b1;
         m_axis.tdata  <= DATA_WIDTH'(sum >> AVG_SHIFT);
         m_axis.tlast  <= s1.last;
         m_axis.tuser  <= sof_pend;
      end else if (m_axis.tready) begin
         m_axis.tvalid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ccd_line_avg.sv
// Directed bench: 8-column averager (4 lines) and a bypass instance.
`timescale 1ns/1ps
module tb_ccd_line_avg;
   logic clk;
   logic rst_n;
   logic err;
   logic b_err;

   ccd_line_avg_if #(.DATA_WIDTH(8)) s_if ();
   ccd_line_avg_if #(.DATA_WIDTH(8)) m_if ();
   ccd_line_avg_if #(.DATA_WIDTH(8)) bs_if ();
   ccd_line_avg_if #(.DATA_WIDTH(8)) bm_if ();

   ccd_line_avg #(
      .DATA_WIDTH(8), .COLS(8), .AVG_SHIFT(2), .ADDR_W(3)
   ) u_avg (
      .pixel_clk(clk), .rst_n(rst_n),
      .s_axis(s_if), .m_axis(m_if), .line_err(err)
   );

   ccd_line_avg #(
      .DATA_WIDTH(8), .COLS(8), .AVG_SHIFT(0), .ADDR_W(3)
   ) u_byp (
      .pixel_clk(clk), .rst_n(rst_n),
      .s_axis(bs_if), .m_axis(bm_if), .line_err(b_err)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       u;
   } beat_t;

   typedef struct {
      logic v; logic [7:0] d; logic l; logic u;
      logic ev; logic [7:0] ed; logic el; logic eu; logic ee;
   } vec_t;

   int    nchk = 0;
   int    nerr = 0;
   string phase = "reset";
   beat_t q[$];
   bit    bp_en = 0;
   int    bp_i = 0;
   bit    hold_p = 0;
   beat_t hold_b;
   vec_t  tv[9];

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout in phase %s", phase);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s/%s: got %0d expected %0d", phase, name, act, exp);
      end
   endtask

   initial begin
      m_if.tready = 1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_en) begin
            m_if.tready = (bp_i % 4 == 0) || (bp_i % 4 == 3);
            bp_i++;
         end else begin
            m_if.tready = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_p) begin
            check("stall_valid", m_if.tvalid, 1);
            check("stall_data", {m_if.tdata, m_if.tlast, m_if.tuser}, hold_b);
         end
         if (!s_if.tready)
            check("tready_drop", m_if.tvalid && !m_if.tready, 1);
         hold_p = m_if.tvalid && !m_if.tready;
         hold_b = '{m_if.tdata, m_if.tlast, m_if.tuser};
         if (m_if.tvalid && m_if.tready)
            q.push_back('{m_if.tdata, m_if.tlast, m_if.tuser});
      end
   end

   task automatic idle();
      s_if.tvalid = 0;
      s_if.tlast  = 0;
      s_if.tuser  = 0;
   endtask

   task automatic send_pix(input logic [7:0] d, input logic l, input logic u);
      int n = 0;
      s_if.tdata  = d;
      s_if.tlast  = l;
      s_if.tuser  = u;
      s_if.tvalid = 1;
      @(negedge clk);
      while (!s_if.tready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_if.tready) begin
         nchk++;
         nerr++;
         $display("FAIL %s/send_timeout: got tready 0 expected 1", phase);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_line(input int n, input int a, input int b, input logic u);
      for (int c = 0; c < n; c++)
         send_pix(8'(a * c + b), c == n - 1, u && c == 0);
   endtask

   task automatic check_line(input int a, input int b, input logic u, input int nd);
      int n = 0;
      while (q.size() < 8 && n < 200) begin
         @(posedge clk);
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      check("beat_count", q.size(), 8);
      for (int c = 0; c < q.size() && c < 8; c++) begin
         if (c < nd) check("avg_data", q[c].d, a * c + b);
         check("avg_last", q[c].l, c == 7);
         check("avg_user", q[c].u, u && c == 0);
      end
      q.delete();
   endtask

   initial begin
      rst_n = 0;
      idle();
      bs_if.tvalid = 0; bs_if.tdata = 0; bs_if.tlast = 0; bs_if.tuser = 0;
      bm_if.tready = 1;
      repeat (3) @(negedge clk);
      check("m_tvalid", m_if.tvalid, 0);
      check("m_tdata", m_if.tdata, 0);
      check("m_tlast", m_if.tlast, 0);
      check("m_tuser", m_if.tuser, 0);
      check("line_err", err, 0);
      check("s_tready", s_if.tready, 1);
      check("b_tvalid", bm_if.tvalid, 0);
      check("b_tready", bs_if.tready, 1);
      @(posedge clk);
      #1;
      rst_n = 1;
      repeat (2) @(posedge clk);
      #1;

      phase = "const";
      send_line(8, 0, 10, 1);
      send_line(8, 0, 20, 0);
      send_line(8, 0, 30, 0);
      idle();
      @(negedge clk);
      check("no_early_out", q.size(), 0);
      check("no_early_valid", m_if.tvalid, 0);
      @(posedge clk);
      #1;
      send_pix(40, 0, 0);
      idle();
      @(negedge clk);
      check("lat_cycle1_valid", m_if.tvalid, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("lat_cycle2_valid", m_if.tvalid, 1);
      check("lat_cycle2_data", m_if.tdata, 25);
      check("lat_cycle2_user", m_if.tuser, 1);
      @(posedge clk);
      #1;
      for (int c = 1; c < 8; c++) send_pix(40, c == 7, 0);
      idle();
      check_line(0, 25, 1, 8);

      phase = "ramp";
      for (int k = 0; k < 3; k++) send_line(8, 4, k, 0);
      idle();
      repeat (4) @(posedge clk);
      #1;
      check("no_early_out", q.size(), 0);
      send_line(8, 4, 3, 0);
      idle();
      check_line(4, 1, 0, 8);

      phase = "backpressure";
      bp_en = 1;
      for (int k = 0; k < 4; k++) send_line(8, 30, 3 * k, 0);
      idle();
      check_line(30, 4, 0, 8);
      bp_en = 0;
      repeat (2) @(posedge clk);
      #1;

      phase = "resync";
      send_line(8, 0, 200, 0);
      send_line(8, 0, 200, 0);
      send_line(8, 0, 12, 1);
      send_line(8, 0, 24, 0);
      send_line(8, 0, 36, 0);
      idle();
      repeat (4) @(posedge clk);
      #1;
      check("no_early_out", q.size(), 0);
      send_line(8, 0, 48, 0);
      idle();
      check_line(0, 30, 1, 8);

      phase = "short_line";
      send_line(6, 0, 50, 0);
      idle();
      @(negedge clk);
      check("err_pulse", err, 1);
      @(negedge clk);
      check("err_width", err, 0);
      @(posedge clk);
      #1;
      send_line(8, 0, 10, 0);
      send_line(8, 0, 20, 0);
      send_line(8, 0, 30, 0);
      idle();
      check_line(0, 27, 0, 6);

      phase = "long_line";
      for (int c = 0; c < 8; c++) send_pix(5, 0, 0);
      idle();
      @(negedge clk);
      check("err_wrap", err, 1);
      @(posedge clk);
      #1;
      send_pix(5, 1, 0);
      idle();
      @(negedge clk);
      check("err_tlast9", err, 1);
      @(posedge clk);
      #1;

      phase = "bypass";
      tv[0] = '{1, 8'd0,   0, 1,  0, 8'd0,   0, 0, 0};
      tv[1] = '{1, 8'd255, 0, 0,  0, 8'd0,   0, 0, 0};
      tv[2] = '{1, 8'd7,   1, 0,  1, 8'd0,   0, 1, 0};
      tv[3] = '{0, 8'd0,   0, 0,  1, 8'd255, 0, 0, 1};
      tv[4] = '{1, 8'd128, 0, 0,  1, 8'd7,   1, 0, 0};
      tv[5] = '{1, 8'd1,   1, 1,  0, 8'd0,   0, 0, 0};
      tv[6] = '{0, 8'd0,   0, 0,  1, 8'd128, 0, 0, 1};
      tv[7] = '{0, 8'd0,   0, 0,  1, 8'd1,   1, 1, 0};
      tv[8] = '{0, 8'd0,   0, 0,  0, 8'd0,   0, 0, 0};
      for (int i = 0; i < 9; i++) begin
         bs_if.tvalid = tv[i].v;
         bs_if.tdata  = tv[i].d;
         bs_if.tlast  = tv[i].l;
         bs_if.tuser  = tv[i].u;
         @(negedge clk);
         check("b_valid", bm_if.tvalid, tv[i].ev);
         if (tv[i].ev) begin
            check("b_data", bm_if.tdata, tv[i].ed);
            check("b_last", bm_if.tlast, tv[i].el);
            check("b_user", bm_if.tuser, tv[i].eu);
         end
         check("b_err", b_err, tv[i].ee);
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end
endmodule
